// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control unit: FSM state and the bundle of
// per-stage enable/bubble strobes it produces.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {CTRL_RUN, CTRL_DRAIN} ctrl_state_t;

    // Enable index: which pipeline register (PC, IF/ID, ID/EX, EX/MM) loads.
    localparam int EN_IF = 0;
    localparam int EN_ID = 1;
    localparam int EN_EX = 2;
    localparam int EN_MM = 3;

    // Bubble index: which stage receives a bubble in its input register.
    localparam int BUB_ID = 0;
    localparam int BUB_EX = 1;
    localparam int BUB_MM = 2;
    localparam int BUB_WB = 3;

    typedef struct packed {
        logic       redirect;
        logic [3:0] bub;
        logic [3:0] en;
    } ctrl_out_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage control outputs exchanged between the datapath
// (master) and the pipeline control unit (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_fwd;
    logic             if_busy;
    logic             mm_busy;
    logic             div_busy;
    logic             exc_valid;
    logic             cnt_clr;
    logic             en_if;
    logic             en_id;
    logic             en_ex;
    logic             en_mm;
    logic             bub_id;
    logic             bub_ex;
    logic             bub_mm;
    logic             bub_wb;
    logic             redirect;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output stall_fwd, if_busy, mm_busy, div_busy, exc_valid, cnt_clr,
        input  en_if, en_id, en_ex, en_mm,
        input  bub_id, bub_ex, bub_mm, bub_wb,
        input  redirect, stall_cycles
    );

    modport slave (
        input  stall_fwd, if_busy, mm_busy, div_busy, exc_valid, cnt_clr,
        output en_if, en_id, en_ex, en_mm,
        output bub_id, bub_ex, bub_mm, bub_wb,
        output redirect, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // NOTE: flop state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: turns hazard/busy/exception inputs into per-stage
// enables and bubbles, drains a stale fetch after a redirect, counts IF stalls.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    pipeline_ctrl_if.slave  bus
);

    ctrl_state_t r_state;
    logic        r_exc_blk;
    ctrl_out_t   w_ctl;
    logic        w_draining;
    logic        w_take_exc;

    assign w_draining = (r_state == CTRL_DRAIN);
    // The cycle after a redirect MM holds a bubble, so a still-high exc_valid is stale.
    assign w_take_exc = !w_draining && !r_exc_blk && bus.exc_valid && !bus.mm_busy;

    // NOTE: every field gets a default before the priority chain, so no path leaves a latch.
    always_comb begin
        w_ctl = '{redirect: 1'b0, bub: 4'h0, en: 4'hF};
        if (!resetn) begin
            w_ctl.en  = 4'h0;
            w_ctl.bub = 4'hF;
        end else begin
            if (w_take_exc) begin
                w_ctl.redirect = 1'b1;
                w_ctl.bub      = 4'hF;
            end else if (bus.mm_busy) begin
                w_ctl.en[EN_MM:EN_IF] = 4'h0;
                w_ctl.bub[BUB_WB]     = 1'b1;
            end else if (bus.div_busy) begin
                w_ctl.en[EN_EX:EN_IF] = 3'h0;
                w_ctl.bub[BUB_MM]     = 1'b1;
            end else if (bus.stall_fwd) begin
                w_ctl.en[EN_ID:EN_IF] = 2'h0;
                w_ctl.bub[BUB_EX]     = 1'b1;
            end else if (bus.if_busy) begin
                w_ctl.en[EN_IF]   = 1'b0;
                w_ctl.bub[BUB_ID] = 1'b1;
            end
            // Whatever fetch is in flight (or returns) while draining is discarded.
            if (w_draining) begin
                w_ctl.en[EN_IF]   = 1'b0;
                w_ctl.bub[BUB_ID] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= CTRL_RUN;
            r_exc_blk <= 1'b0;
        end else begin
            r_exc_blk <= w_take_exc;
            case (r_state)
                CTRL_RUN:   if (w_take_exc && bus.if_busy) r_state <= CTRL_DRAIN;
                CTRL_DRAIN: if (!bus.if_busy)              r_state <= CTRL_RUN;
                default:                                   r_state <= CTRL_RUN;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (!w_ctl.en[EN_IF]),
        .clr    (bus.cnt_clr),
        .q      (bus.stall_cycles)
    );

    assign bus.en_if    = w_ctl.en[EN_IF];
    assign bus.en_id    = w_ctl.en[EN_ID];
    assign bus.en_ex    = w_ctl.en[EN_EX];
    assign bus.en_mm    = w_ctl.en[EN_MM];
    assign bus.bub_id   = w_ctl.bub[BUB_ID];
    assign bus.bub_ex   = w_ctl.bub[BUB_EX];
    assign bus.bub_mm   = w_ctl.bub[BUB_MM];
    assign bus.bub_wb   = w_ctl.bub[BUB_WB];
    assign bus.redirect = w_ctl.redirect;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a stall-depth reference model.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // {redirect, bub_wb, bub_mm, bub_ex, bub_id, en_mm, en_ex, en_id, en_if}
    logic [8:0] dut_out;
    assign dut_out = {bus.redirect, bus.bub_wb, bus.bub_mm, bus.bub_ex, bus.bub_id,
                      bus.en_mm, bus.en_ex, bus.en_id, bus.en_if};

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: fetch being drained, MM known flushed, counter value.
    bit m_drain = 1'b0;
    bit m_blk   = 1'b0;
    int m_cnt   = 0;

    // A hazard freezes the first n pipeline registers and bubbles the stage behind them.
    function automatic logic [8:0] model_out(input logic sf, ib, mb, db, ev);
        int         n;
        logic [3:0] en;
        logic [3:0] bub;
        if (!resetn) return {1'b0, 4'hF, 4'h0};
        if (!m_drain && !m_blk && ev && !mb) return 9'h1FF;
        n   = mb ? 4 : db ? 3 : sf ? 2 : (ib && !m_drain) ? 1 : 0;
        en  = 4'hF;
        en  = en << n;
        bub = (n == 0) ? 4'h0 : 4'(1 << (n - 1));
        if (m_drain) begin
            en[0]  = 1'b0;
            bub[0] = 1'b1;
        end
        return {1'b0, bub, en};
    endfunction

    task automatic model_reset();
        m_drain = 1'b0;
        m_blk   = 1'b0;
        m_cnt   = 0;
    endtask

    // Drive one cycle, sample mid-cycle, advance the model on the rising edge.
    task automatic run_cycle(input logic sf, ib, mb, db, ev, clr,
                             output logic [8:0] obs, output logic [8:0] exp,
                             output int obs_cnt, output int exp_cnt);
        bus.stall_fwd = sf;
        bus.if_busy   = ib;
        bus.mm_busy   = mb;
        bus.div_busy  = db;
        bus.exc_valid = ev;
        bus.cnt_clr   = clr;
        @(negedge clk);
        obs     = dut_out;
        exp     = model_out(sf, ib, mb, db, ev);
        obs_cnt = int'(bus.stall_cycles);
        exp_cnt = m_cnt;
        @(posedge clk);
        if (resetn) begin
            if (clr) m_cnt = 0;
            else if (!exp[0] && m_cnt < SAT) m_cnt++;
            m_drain = m_drain ? ib : (exp[8] && ib);
            m_blk   = exp[8];
        end
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        #1;
        exp = model_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dut_out !== exp) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", dut_out, exp);
        end
        vectors++;
        if (bus.stall_cycles !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_counter: got %0d expected 0", bus.stall_cycles);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_fwd_stall();
        logic [8:0] obs, exp;
        int oc, ec;
        run_cycle(1, 0, 0, 0, 0, 0, obs, exp, oc, ec);
        vectors++;
        if (obs !== exp || obs !== 9'b0_0010_1100) begin
            miscompares++;
            $display("FAIL fwd_stall: got %b expected %b", obs, exp);
        end
        run_cycle(0, 0, 0, 0, 0, 0, obs, exp, oc, ec);
        vectors++;
        if (obs !== exp || oc !== 1) begin
            miscompares++;
            $display("FAIL fwd_count: got %b/%0d expected %b/1", obs, oc, exp);
        end
    endtask

    task automatic test_mm_stall();
        logic [8:0] obs, exp;
        int oc, ec, start;
        start = m_cnt;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1, 0, 1, 0, 0, 0, obs, exp, oc, ec);
            vectors++;
            if (obs !== exp || obs !== 9'b0_1000_0000) begin
                miscompares++;
                $display("FAIL mm_stall[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        run_cycle(0, 0, 0, 0, 0, 0, obs, exp, oc, ec);
        vectors++;
        if (oc !== start + 3 || oc !== ec) begin
            miscompares++;
            $display("FAIL mm_count: got %0d expected %0d", oc, start + 3);
        end
    endtask

    task automatic test_exc_drain();
        logic [8:0] obs, exp;
        int oc, ec, pulses;
        logic [1:0] seq [7] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            run_cycle(0, seq[i][0], 0, 0, seq[i][1], 0, obs, exp, oc, ec);
            pulses += int'(obs[8]);
            vectors++;
            if (obs !== exp || oc !== ec) begin
                miscompares++;
                $display("FAIL exc_drain[%0d]: got %b/%0d expected %b/%0d", i, obs, oc, exp, ec);
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL exc_drain_pulses: got %0d expected 1", pulses);
        end
        // exc_valid with the fetch already complete: no drain afterwards.
        run_cycle(0, 0, 0, 0, 1, 0, obs, exp, oc, ec);
        run_cycle(0, 0, 0, 0, 0, 0, obs, exp, oc, ec);
        vectors++;
        if (obs !== exp || obs !== 9'b0_0000_1111) begin
            miscompares++;
            $display("FAIL exc_no_drain: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_exc_held();
        logic [8:0] obs, exp;
        int oc, ec, pulses;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 0, 0, 0, (i < 2), 0, obs, exp, oc, ec);
            pulses += int'(obs[8]);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL exc_held[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL exc_held_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_saturation();
        logic [8:0] obs, exp;
        int oc, ec;
        for (int i = 0; i < 20; i++) begin
            run_cycle(0, 1, 0, 0, 0, 0, obs, exp, oc, ec);
            vectors++;
            if (oc !== ec) begin
                miscompares++;
                $display("FAIL sat_count[%0d]: got %0d expected %0d", i, oc, ec);
            end
        end
        run_cycle(0, 1, 0, 0, 0, 1, obs, exp, oc, ec);
        vectors++;
        if (oc !== SAT) begin
            miscompares++;
            $display("FAIL sat_hold: got %0d expected %0d", oc, SAT);
        end
        run_cycle(0, 1, 0, 0, 0, 0, obs, exp, oc, ec);
        vectors++;
        if (oc !== 0) begin
            miscompares++;
            $display("FAIL sat_clear: got %0d expected 0", oc);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [8:0] obs, exp;
        int oc, ec;
        run_cycle(0, 1, 0, 0, 1, 0, obs, exp, oc, ec);
        run_cycle(0, 1, 0, 0, 0, 0, obs, exp, oc, ec);
        resetn = 1'b0;
        #1;
        exp = model_out(0, 1, 0, 0, 0);
        vectors++;
        if (dut_out !== exp || bus.stall_cycles !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_in_drain: got %b/%0d expected %b/0", dut_out, bus.stall_cycles, exp);
        end
        model_reset();
        #2;
        resetn = 1'b1;
        run_cycle(0, 0, 0, 0, 0, 0, obs, exp, oc, ec);
        vectors++;
        if (obs !== exp || obs !== 9'b0_0000_1111 || oc !== 0) begin
            miscompares++;
            $display("FAIL restart_run: got %b/%0d expected %b/0", obs, oc, exp);
        end
    endtask

    task automatic test_random();
        logic [8:0] obs, exp;
        int oc, ec;
        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom_range(2) == 0), ($urandom_range(2) == 0),
                      ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                      ($urandom_range(3) == 0), ($urandom_range(15) == 0),
                      obs, exp, oc, ec);
            vectors++;
            if (obs !== exp || oc !== ec) begin
                miscompares++;
                $display("FAIL random[%0d]: got %b/%0d expected %b/%0d", i, obs, oc, exp, ec);
            end
        end
    endtask

    initial begin
        bus.stall_fwd = 1'b0;
        bus.if_busy   = 1'b0;
        bus.mm_busy   = 1'b0;
        bus.div_busy  = 1'b0;
        bus.exc_valid = 1'b0;
        bus.cnt_clr   = 1'b0;
        test_reset();
        test_fwd_stall();
        test_mm_stall();
        test_exc_drain();
        test_exc_held();
        test_saturation();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
